ls_arbiter: RTL
===============

Name: ls_arbiter

Overview:
- Arbitrates the single-ported 128-bit local store (LS) between three requesters: DMA, the load/store pipe (LSU) and instruction fetch (IF).
- Issues at most one quadword access per cycle and registers the read data back to the winner.
- IF requests are serviced as fixed-length bursts.
- A starvation counter guarantees IF forward progress under sustained DMA/LSU traffic.

Parameters:
- MEM_SIZE, LS_SIZE/16, LS depth in quadwords (power of two).
- IF_BURST, 4, quadwords per instruction-fetch burst (1..16).
- STARVE_LIMIT, 8, cycles IF may wait with if_req high before it is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- dma_req  in  1  DMA access request, held until dma_gnt
- dma_wr  in  1  1=write, 0=read
- dma_addr  in  32  byte address [0:31]
- dma_wdata  in  128  write data [0:127]
- dma_gnt  out  1  one-cycle grant
- dma_rvalid  out  1  read data valid (one cycle after grant of a read)
- dma_rdata  out  128  read data
- lsu_req, lsu_wr, lsu_addr, lsu_wdata, lsu_gnt, lsu_rvalid, lsu_rdata  same widths/semantics as DMA
- if_req  in  1  fetch burst request, held until if_gnt
- if_addr  in  32  burst start byte address
- if_gnt  out  1  one-cycle pulse when burst accepted
- if_rvalid  out  1  fetch beat valid
- if_rdata  out  128  fetch beat data
- if_last  out  1  qualifies the final beat of the burst
- ls_addr  out  32  quadword index to LS
- ls_wr_en  out  1  LS write enable
- ls_data_wr  out  128  LS write data
- ls_data_rd  in  128  LS read data (combinational, same cycle as ls_addr)

Behaviour:
- Reset (async, rst=1): every output 0, FSM=IDLE, starve counter=0, pending-read tags cleared. Asserting reset mid-burst aborts the burst; no further if_rvalid is produced.
- Address conversion: ls_addr = (byte_addr >> 4) & (MEM_SIZE-1), zero-extended to 32 bits. Byte offset bits [28:31] are ignored.
- ls_addr, ls_wr_en and ls_data_wr are combinational from the current-cycle winner. When nothing is granted: ls_wr_en=0, ls_addr=0, ls_data_wr=0.
- Priority in IDLE, evaluated each cycle:
  - If starve_cnt == STARVE_LIMIT and if_req=1: IF wins.
  - Otherwise DMA > LSU > IF.
  - Exactly one gnt is asserted per cycle.
- Single access (DMA/LSU):
  - gnt pulses in the cycle the LS access is driven.
  - Write: ls_wr_en=1 that cycle; no rvalid.
  - Read: rvalid=1 and rdata=ls_data_rd (registered) on the next cycle.
  - Back-to-back grants to the same requester are allowed every cycle.
- FSM states: IDLE, BURST.
  - IDLE -> BURST on IF win: if_gnt=1 and beat 0 read at if_addr in the same cycle; base address and beat counter are latched.
  - In BURST, beat k reads quadword index (base+k) mod MEM_SIZE. The index wraps at MEM_SIZE.
  - BURST -> IDLE after beat IF_BURST-1 is issued. The next arbitration happens in the cycle after the last beat.
  - During BURST, dma_gnt and lsu_gnt stay 0. A burst is never preempted.
  - IF_BURST=1: no BURST cycles; IDLE issues the single beat and stays in IDLE.
- if_rvalid/if_rdata follow each beat issue by one cycle. if_last=1 with the final beat's rvalid.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle if_req=1 and if_gnt=0.
  - Clears on if_gnt.
  - Also clears when if_req=0.
- Simultaneous write and read to the same address by different requesters cannot occur (one grant per cycle).
- A read issued the cycle after a write to the same address returns the new data.
- LS write-forwarding (ls_data_rd = ls_data_wr when ls_wr_en) is never relied on, since reads and writes are never issued in the same cycle.
- Requests that drop before gnt are legal and are simply not served.

Test Plan:
- Reset mid-burst: if_req, if_addr=0x100, IF_BURST=4, assert rst after beat 1 -> all outputs 0 immediately; no if_rvalid after reset.
- Priority: dma_req, lsu_req and if_req all high in the same cycle -> dma_gnt cycle 0, lsu_gnt cycle 1, if_gnt cycle 2, beats at quadword indices 0x10..0x13. Stimulus: dma read 0x40, lsu write 0x50, if 0x100.
- Write then read: lsu write 0x20 with data 0xDEADBEEF_... then dma read 0x20 next cycle -> dma_rvalid with the same 128-bit value one cycle after dma_gnt.
- Starvation: dma_req held high continuously and if_req high -> if_gnt after exactly STARVE_LIMIT=8 DMA grants; DMA receives no grant for 4 cycles; starve counter then returns to 0.
- Wrap: IF_BURST=4, if_addr = (MEM_SIZE-2)*16 -> beats read indices MEM_SIZE-2, MEM_SIZE-1, 0, 1; if_last on the 4th rvalid.
- Offset ignore: lsu read at byte 0x2F -> ls_addr=0x2; a DMA request during a burst -> dma_gnt delayed until the cycle after the last beat.

Source files
------------

// File: rtl/ls_arbiter_if.sv
// Local-store arbiter bus: three requester ports (DMA, LSU, instruction fetch)
// plus the single-ported 128-bit local-store access port.
interface ls_arbiter_if;
    // DMA requester
    logic         dma_req;
    logic         dma_wr;
    logic [31:0]  dma_addr;
    logic [127:0] dma_wdata;
    logic         dma_gnt;
    logic         dma_rvalid;
    logic [127:0] dma_rdata;
    // Load/store pipe requester
    logic         lsu_req;
    logic         lsu_wr;
    logic [31:0]  lsu_addr;
    logic [127:0] lsu_wdata;
    logic         lsu_gnt;
    logic         lsu_rvalid;
    logic [127:0] lsu_rdata;
    // Instruction-fetch burst requester
    logic         if_req;
    logic [31:0]  if_addr;
    logic         if_gnt;
    logic         if_rvalid;
    logic [127:0] if_rdata;
    logic         if_last;
    // Local-store port
    logic [31:0]  ls_addr;
    logic         ls_wr_en;
    logic [127:0] ls_data_wr;
    logic [127:0] ls_data_rd;

    // Arbiter side
    modport slave (
        input  dma_req, dma_wr, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        input  lsu_req, lsu_wr, lsu_addr, lsu_wdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_last,
        output ls_addr, ls_wr_en, ls_data_wr,
        input  ls_data_rd
    );

    // Requesters and local-store side
    modport master (
        output dma_req, dma_wr, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        output lsu_req, lsu_wr, lsu_addr, lsu_wdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_last,
        input  ls_addr, ls_wr_en, ls_data_wr,
        output ls_data_rd
    );
endinterface

// File: rtl/ls_arbiter.sv
// Local-store arbiter: one quadword access per cycle shared between DMA, LSU
// and instruction fetch. Fetches run as non-preemptible fixed-length bursts;
// a starvation counter forces a fetch win after STARVE_LIMIT waiting cycles.
// Addresses are byte addresses; the low 4 bits (quadword offset) are ignored.
module ls_arbiter #(
    parameter int MEM_SIZE     = 16384,
    parameter int IF_BURST     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    ls_arbiter_if.slave bus
);
    localparam int IDX_W  = $clog2(MEM_SIZE);
    localparam int BEAT_W = (IF_BURST > 1) ? $clog2(IF_BURST) : 1;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_base;
    logic [BEAT_W-1:0]  r_beat;
    logic [CNT_W-1:0]   r_starve;

    logic               w_force_if;
    logic               w_dma_gnt;
    logic               w_lsu_gnt;
    logic               w_if_gnt;
    logic               w_if_beat;
    logic               w_if_last;
    logic [IDX_W-1:0]   w_idx;
    logic               w_wr_en;
    logic [127:0]       w_wdata;

    logic               r_dma_rvalid;
    logic [127:0]       r_dma_rdata;
    logic               r_lsu_rvalid;
    logic [127:0]       r_lsu_rdata;
    logic               r_if_rvalid;
    logic [127:0]       r_if_rdata;
    logic               r_if_last;

    // Quadword index of a byte address, wrapped to the store depth.
    function automatic logic [IDX_W-1:0] qw_index(input logic [31:0] byte_addr);
        return byte_addr[4 +: IDX_W];
    endfunction

    assign w_force_if = (r_starve == CNT_W'(STARVE_LIMIT)) && bus.if_req;

    // Winner selection, LS port drive and FSM next state; everything forced
    // idle while reset is held so outputs read 0 immediately.
    always_comb begin
        w_state_nxt = r_state;
        w_dma_gnt   = 1'b0;
        w_lsu_gnt   = 1'b0;
        w_if_gnt    = 1'b0;
        w_if_beat   = 1'b0;
        w_if_last   = 1'b0;
        w_idx       = '0;
        w_wr_en     = 1'b0;
        w_wdata     = '0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_force_if || (bus.if_req && !bus.dma_req && !bus.lsu_req)) begin
                        w_if_gnt  = 1'b1;
                        w_if_beat = 1'b1;
                        w_idx     = qw_index(bus.if_addr);
                        if (IF_BURST == 1) begin
                            w_if_last = 1'b1;
                        end else begin
                            w_state_nxt = BURST;
                        end
                    end else if (bus.dma_req) begin
                        w_dma_gnt = 1'b1;
                        w_idx     = qw_index(bus.dma_addr);
                        w_wr_en   = bus.dma_wr;
                        w_wdata   = bus.dma_wr ? bus.dma_wdata : '0;
                    end else if (bus.lsu_req) begin
                        w_lsu_gnt = 1'b1;
                        w_idx     = qw_index(bus.lsu_addr);
                        w_wr_en   = bus.lsu_wr;
                        w_wdata   = bus.lsu_wr ? bus.lsu_wdata : '0;
                    end
                end
                BURST: begin
                    w_if_beat = 1'b1;
                    w_idx     = r_base + IDX_W'(r_beat);
                    if (r_beat == BEAT_W'(IF_BURST - 1)) begin
                        w_if_last   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Burst base index and beat counter; beat 0 is issued on the grant cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_beat <= '0;
        end else if (r_state == IDLE && w_if_gnt) begin
            r_base <= w_idx;
            r_beat <= BEAT_W'(1);
        end else if (r_state == BURST) begin
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    // Starvation counter: counts waiting fetch cycles, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_if_gnt || !bus.if_req) begin
            r_starve <= '0;
        end else if (r_starve != CNT_W'(STARVE_LIMIT)) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end

    // Read return: capture LS data one cycle after each read issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_rdata  <= '0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_if_last    <= 1'b0;
        end else begin
            r_dma_rvalid <= w_dma_gnt && !bus.dma_wr;
            r_lsu_rvalid <= w_lsu_gnt && !bus.lsu_wr;
            r_if_rvalid  <= w_if_beat;
            r_if_last    <= w_if_last;
            if (w_dma_gnt && !bus.dma_wr) r_dma_rdata <= bus.ls_data_rd;
            if (w_lsu_gnt && !bus.lsu_wr) r_lsu_rdata <= bus.ls_data_rd;
            if (w_if_beat)                r_if_rdata  <= bus.ls_data_rd;
        end
    end

    assign bus.dma_gnt    = w_dma_gnt;
    assign bus.lsu_gnt    = w_lsu_gnt;
    assign bus.if_gnt     = w_if_gnt;
    assign bus.dma_rvalid = r_dma_rvalid;
    assign bus.dma_rdata  = r_dma_rdata;
    assign bus.lsu_rvalid = r_lsu_rvalid;
    assign bus.lsu_rdata  = r_lsu_rdata;
    assign bus.if_rvalid  = r_if_rvalid;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.if_last    = r_if_last;
    assign bus.ls_addr    = {{(32 - IDX_W){1'b0}}, w_idx};
    assign bus.ls_wr_en   = w_wr_en;
    assign bus.ls_data_wr = w_wdata;

    // Quadword offset and out-of-range high address bits carry no meaning here.
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.dma_addr[31:4+IDX_W], bus.dma_addr[3:0],
                             bus.lsu_addr[31:4+IDX_W], bus.lsu_addr[3:0],
                             bus.if_addr[31:4+IDX_W],  bus.if_addr[3:0]};
endmodule
